// File: rtl/bsg_fifo_rolly_reader_ctrl.sv
// Read-side controller for a rolly FIFO: streams entries out and tracks sent entries until ack/nack.
// Zero latency data path; downstream backpressure via ready_and_i, replay throttled by a backoff window.
// Holds v_o low when the outstanding window is full, during backoff, on flush, or on an effective nack.
module bsg_fifo_rolly_reader_ctrl #(
    parameter int lg_size_p = 3,
    parameter int width_p   = 8,
    parameter int window_p  = 2**lg_size_p,
    parameter int backoff_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               empty_i,
    input  logic [width_p-1:0] data_i,
    output logic               r_deq_o,
    output logic               r_incr_o,
    output logic               r_rewind_o,
    output logic               r_forward_o,
    output logic               r_clear_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_and_i,
    input  logic               ack_i,
    input  logic               ack_all_i,
    input  logic               nack_i,
    input  logic               flush_i,
    output logic [lg_size_p:0] outstanding_o,
    output logic               busy_o,
    output logic               err_o
);

    typedef enum logic {STREAM, BACKOFF} state_e;

    localparam logic [lg_size_p:0] window_lp  = (lg_size_p+1)'(window_p);
    localparam logic [7:0]         backoff_lp = 8'(backoff_p);

    state_e             state_r, state_n;
    logic [lg_size_p:0] outstanding_r, outstanding_n;
    logic [7:0]         cnt_r, cnt_n;
    logic               err_r, err_n;
    logic               has_out;
    logic               nack_eff;

    assign has_out  = (outstanding_r != '0);
    // BACKOFF always has zero outstanding, so a nack there is naturally ignored.
    assign nack_eff = nack_i & has_out & ~flush_i;

    always_comb begin
        state_n       = state_r;
        outstanding_n = outstanding_r;
        cnt_n         = cnt_r;
        err_n         = err_r;
        r_incr_o      = 1'b0;
        r_rewind_o    = 1'b0;
        r_forward_o   = 1'b0;
        r_clear_o     = 1'b0;

        v_o = ~reset_i & (state_r == STREAM) & ~empty_i
            & (outstanding_r < window_lp) & ~flush_i & ~nack_eff;
        r_deq_o = v_o & ready_and_i;

        if (state_r == BACKOFF) begin
            cnt_n = cnt_r - 8'd1;
            if (cnt_r == 8'd1)
                state_n = STREAM;
        end

        if (reset_i) begin
            state_n = state_r;
        end else if (flush_i) begin
            r_clear_o     = 1'b1;
            outstanding_n = '0;
            cnt_n         = '0;
            state_n       = STREAM;
        end else if (nack_eff) begin
            // A coincident ack retires the oldest entry so the replay starts after it.
            r_rewind_o    = 1'b1;
            r_incr_o      = ack_i;
            outstanding_n = '0;
            if (backoff_p > 0) begin
                state_n = BACKOFF;
                cnt_n   = backoff_lp;
            end
        end else if (ack_all_i) begin
            r_forward_o   = 1'b1;
            outstanding_n = '0;
        end else begin
            // Same-cycle dequeue is not yet ackable; this keeps the checkpoint behind rptr.
            if (ack_i) begin
                if (has_out)
                    r_incr_o = 1'b1;
                else
                    err_n = 1'b1;
            end
            outstanding_n = outstanding_r + (lg_size_p+1)'(r_deq_o)
                                          - (lg_size_p+1)'(r_incr_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= STREAM;
            outstanding_r <= '0;
            cnt_r         <= '0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_n;
            outstanding_r <= outstanding_n;
            cnt_r         <= cnt_n;
            err_r         <= err_n;
        end
    end

    assign data_o        = data_i;
    assign outstanding_o = outstanding_r;
    assign busy_o        = (state_r == BACKOFF);
    assign err_o         = err_r;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($countones({r_rewind_o, r_forward_o, r_clear_o}) <= 1)
                else $error("rewind/forward/clear asserted together");
            assert (!(r_rewind_o && r_deq_o))
                else $error("rewind coincides with dequeue");
            assert (!(r_incr_o && !has_out))
                else $error("checkpoint increment with nothing outstanding");
        end
    end
`endif

endmodule
